// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: requester count, FSM
// encoding and default timing parameters.
package uart_tx_arbiter_pkg;

  localparam int NUM_REQ              = 4;
  localparam int DEFAULT_CLKS_PER_BIT = 107;
  localparam int DEFAULT_TIMEOUT_BITS = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter_4.sv
// Combinational round-robin selector: the search starts at index ptr and
// wraps, returning a one-hot winner (zero when nothing requests).
module rr_arbiter_4
  import uart_tx_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] grant
);

  logic [1:0] idx;

  // Walk offsets from farthest to nearest so the nearest request wins last.
  always_comb begin
    grant = '0;
    idx   = 2'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among four byte sources,
// with per-owner grant locking and a frame watchdog.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int TIMEOUT_BITS = DEFAULT_TIMEOUT_BITS
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  input  logic [NUM_REQ-1:0]   i_Req_DV,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  input  logic [NUM_REQ-1:0]   i_Req_Lock,
  output logic [NUM_REQ-1:0]   o_Req_Ack,
  output logic                 o_TX_DV,
  output logic [7:0]           o_TX_Byte,
  input  logic                 i_TX_Done,
  output logic [NUM_REQ-1:0]   o_Grant,
  output logic                 o_Busy,
  output logic                 o_Timeout
);

  localparam int LIMIT = CLKS_PER_BIT * TIMEOUT_BITS;
  localparam int WD_W  = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  state_t             state_reg, state_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [1:0]         ptr_reg, ptr_next;
  logic [7:0]         byte_reg, byte_next;
  logic [WD_W-1:0]    wdog_reg, wdog_next;
  logic               timeout_reg, timeout_next;

  logic [NUM_REQ-1:0] win;
  logic [1:0]         win_idx;
  logic [1:0]         own_idx;
  logic               keep_owner;

  rr_arbiter_4 u_rr (
    .req   (i_Req_DV),
    .ptr   (ptr_reg),
    .grant (win)
  );

  assign win_idx    = onehot_to_idx(win);
  assign own_idx    = onehot_to_idx(grant_reg);
  assign keep_owner = |(grant_reg & i_Req_Lock & i_Req_DV);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_reg   <= ST_IDLE;
      grant_reg   <= '0;
      ptr_reg     <= 2'd0;
      byte_reg    <= 8'h00;
      wdog_reg    <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      ptr_reg     <= ptr_next;
      byte_reg    <= byte_next;
      wdog_reg    <= wdog_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    ptr_next     = ptr_reg;
    byte_next    = byte_reg;
    wdog_next    = wdog_reg;
    timeout_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (|i_Req_DV) begin
          state_next = ST_SEND;
          grant_next = win;
          byte_next  = i_Req_Byte[{win_idx, 3'b000} +: 8];
          ptr_next   = win_idx + 2'd1;
        end
      end
      ST_SEND: begin
        state_next = ST_WAIT;
        wdog_next  = '0;
      end
      ST_WAIT: begin
        if (i_TX_Done) begin
          if (keep_owner) begin
            state_next = ST_SEND;
            byte_next  = i_Req_Byte[{own_idx, 3'b000} +: 8];
          end else begin
            state_next = ST_IDLE;
            grant_next = '0;
          end
        end else if (wdog_reg == WD_W'(LIMIT - 1)) begin
          // A missing end-of-frame must not strand the bus with its owner.
          state_next   = ST_IDLE;
          grant_next   = '0;
          timeout_next = 1'b1;
        end else begin
          wdog_next = wdog_reg + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        grant_next = '0;
      end
    endcase
  end

  assign o_TX_DV   = (state_reg == ST_SEND);
  assign o_Req_Ack = grant_reg & {NUM_REQ{state_reg == ST_SEND}};
  assign o_TX_Byte = byte_reg;
  assign o_Grant   = grant_reg;
  assign o_Busy    = (state_reg != ST_IDLE);
  assign o_Timeout = timeout_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed vectors, corner-case
// sequences and a randomized run against a transaction-level model.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  dv;
  logic [31:0] req_byte;
  logic [3:0]  lock;
  logic [3:0]  ack;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        done;
  logic [3:0]  grant;
  logic        busy;
  logic        timeout;

  int n_tests;
  int n_fail;
  int ack_pulses;

  uart_tx_arbiter dut (
    .i_Clk      (clk),
    .i_Rst_L    (rst_n),
    .i_Req_DV   (dv),
    .i_Req_Byte (req_byte),
    .i_Req_Lock (lock),
    .o_Req_Ack  (ack),
    .o_TX_DV    (tx_dv),
    .o_TX_Byte  (tx_byte),
    .i_TX_Done  (done),
    .o_Grant    (grant),
    .o_Busy     (busy),
    .o_Timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] dv;
    logic [3:0] ack;
    logic [7:0] tx_byte;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (ack != 4'b0) ack_pulses++;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    dv       = 4'b0;
    lock     = 4'b0;
    done     = 1'b0;
    req_byte = 32'h4332_2110;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic end_frame();
    dv = 4'b0;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  function automatic int rr_pick(input logic [3:0] req, input int last);
    for (int i = 1; i <= 4; i++) begin
      if (req[(last + i) % 4]) return (last + i) % 4;
    end
    return -1;
  endfunction

  // Randomized-run model state
  logic [7:0] qbuf [4][8];
  int qhead [4];
  int qlen  [4];
  int m_phase;  // 0 idle, 1 strobe cycle, 2 awaiting end of frame
  int m_owner;
  int m_last;
  int cd;

  initial begin
    int cycles;
    int strobes;
    int acks0;
    int frames_left;
    int frame_no;
    int w;

    n_tests    = 0;
    n_fail     = 0;
    ack_pulses = 0;

    vecs[0] = '{4'b1111, 4'b0001, 8'h10};
    vecs[1] = '{4'b1001, 4'b1000, 8'h43};
    vecs[2] = '{4'b0110, 4'b0010, 8'h21};
    vecs[3] = '{4'b0011, 4'b0001, 8'h10};
    vecs[4] = '{4'b0001, 4'b0001, 8'h10};
    vecs[5] = '{4'b1100, 4'b0100, 8'h32};
    vecs[6] = '{4'b1100, 4'b1000, 8'h43};
    vecs[7] = '{4'b0101, 4'b0001, 8'h10};

    // Reset state
    rst_n = 1'b0; dv = 4'b0; lock = 4'b0; done = 1'b0; req_byte = '0;
    #3;
    check("rst_async_busy", {31'b0, busy}, 32'd0);
    tick();
    check("rst_outputs", {ack, tx_dv, tx_byte, grant, busy, timeout}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single request, 1000-cycle frame
    dv = 4'b0001; req_byte[7:0] = 8'h41;
    tick();
    check("single_strobe", {31'b0, tx_dv}, 32'd1);
    check("single_ack", {28'b0, ack}, 32'h1);
    check("single_byte", {24'b0, tx_byte}, 32'h41);
    check("single_grant", {28'b0, grant}, 32'h1);
    dv = 4'b0;
    strobes = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (tx_dv) strobes++;
    end
    check("single_no_restrobe", strobes, 0);
    check("single_busy_wait", {31'b0, busy}, 32'd1);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("single_idle_after_done", {27'b0, busy, grant}, 32'd0);
    check("single_byte_hold", {24'b0, tx_byte}, 32'h41);
    $display("[TB] single request frame done");

    // Table-driven arbitration from a fresh pointer
    do_reset();
    for (int v = 0; v < 8; v++) begin
      dv = vecs[v].dv;
      tick();
      check($sformatf("vec%0d_strobe", v), {31'b0, tx_dv}, 32'd1);
      check($sformatf("vec%0d_ack", v), {28'b0, ack}, {28'b0, vecs[v].ack});
      check($sformatf("vec%0d_byte", v), {24'b0, tx_byte}, {24'b0, vecs[v].tx_byte});
      end_frame();
      check($sformatf("vec%0d_idle", v), {31'b0, busy}, 32'd0);
      $display("[TB] vec %0d dv=%b ack=%b byte=%02h", v, vecs[v].dv, ack, tx_byte);
    end

    // All four continuously requesting
    do_reset();
    dv = 4'b1111;
    acks0 = ack_pulses;
    for (int f = 0; f < 5; f++) begin
      cycles = 0;
      while (!tx_dv && cycles < 10) begin
        tick();
        cycles++;
      end
      check($sformatf("rr%0d_strobe_seen", f), {31'b0, tx_dv}, 32'd1);
      check($sformatf("rr%0d_ack", f), {28'b0, ack}, 32'(1 << (f % 4)));
      check($sformatf("rr%0d_byte", f), {24'b0, tx_byte}, 32'(8'h10 + 8'h11 * (f % 4)));
      $display("[TB] rr frame %0d ack=%b byte=%02h", f, ack, tx_byte);
      repeat (3) tick();
      done = 1'b1;
      tick();
      done = 1'b0;
    end
    check("rr_ack_count", ack_pulses - acks0, 5);
    dv = 4'b0;
    repeat (3) tick();

    // Locked owner keeps the grant across three bytes
    do_reset();
    lock = 4'b0100; dv = 4'b0100; req_byte[23:16] = 8'hA0;
    tick();
    check("lock0_ack", {28'b0, ack}, 32'h4);
    check("lock0_byte", {24'b0, tx_byte}, 32'hA0);
    req_byte[23:16] = 8'hA1; req_byte[15:8] = 8'h55; dv = 4'b0110;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    check("lock1_ack", {27'b0, tx_dv, ack}, 32'h14);
    check("lock1_byte", {24'b0, tx_byte}, 32'hA1);
    req_byte[23:16] = 8'hA2;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    check("lock2_ack", {27'b0, tx_dv, ack}, 32'h14);
    check("lock2_byte", {24'b0, tx_byte}, 32'hA2);
    dv = 4'b0010; lock = 4'b0;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    check("lock_release_idle", {27'b0, busy, grant}, 32'd0);
    tick();
    check("lock_next_ack", {27'b0, tx_dv, ack}, 32'h12);
    check("lock_next_byte", {24'b0, tx_byte}, 32'h55);
    $display("[TB] lock sequence done");
    end_frame();

    // Watchdog
    do_reset();
    dv = 4'b0001;
    tick();
    dv = 4'b0;
    tick();
    cycles = 0;
    while (!timeout && cycles < 2000) begin
      tick();
      cycles++;
    end
    check("wdog_cycles", cycles, 1284);
    check("wdog_grant_busy", {27'b0, busy, grant}, 32'd0);
    tick();
    check("wdog_pulse_width", {31'b0, timeout}, 32'd0);
    $display("[TB] watchdog fired after %0d cycles", cycles);

    // Reset mid-frame
    do_reset();
    dv = 4'b0001; req_byte[7:0] = 8'h77;
    tick();
    dv = 4'b0;
    tick();
    check("midrst_busy_before", {31'b0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {ack, tx_dv, tx_byte, grant, busy, timeout}, 32'd0);
    dv = 4'b1001; req_byte[31:24] = 8'h33;
    acks0 = ack_pulses;
    repeat (2) tick();
    check("midrst_no_ack", ack_pulses - acks0, 0);
    rst_n = 1'b1;
    tick();
    check("midrst_winner", {27'b0, tx_dv, ack}, 32'h11);
    check("midrst_byte", {24'b0, tx_byte}, 32'h77);
    $display("[TB] mid-frame reset recovered");
    end_frame();

    // Done in IDLE, withdrawal, done in SEND
    do_reset();
    done = 1'b1;
    tick();
    done = 1'b0;
    check("idle_done_ignored", {27'b0, busy, ack}, 32'd0);
    dv = 4'b0010;
    #2;
    dv = 4'b0;
    tick();
    check("withdraw_no_ack", {27'b0, busy, ack}, 32'd0);
    dv = 4'b0010; req_byte[15:8] = 8'h5A;
    tick();
    check("send_strobe", {27'b0, tx_dv, ack}, 32'h12);
    done = 1'b1; dv = 4'b0;
    tick();
    done = 1'b0;
    check("send_done_ignored", {30'b0, busy, tx_dv}, 32'h2);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("send_then_idle", {31'b0, busy}, 32'd0);
    $display("[TB] ignored-done and withdrawal sequence done");

    // Randomized run against the transaction model
    do_reset();
    for (int k = 0; k < 4; k++) begin
      qhead[k] = 0;
      qlen[k]  = 0;
    end
    m_phase = 0; m_owner = -1; m_last = 3; cd = 0;
    frames_left = 150;
    frame_no = 0;
    cycles = 0;
    while ((frames_left > 0 || m_phase != 0 || qlen[0] + qlen[1] + qlen[2] + qlen[3] != 0)
           && cycles < 20000) begin
      check("rnd_strobe", {31'b0, tx_dv}, {31'b0, m_phase == 1});
      check("rnd_busy", {31'b0, busy}, {31'b0, m_phase != 0});
      check("rnd_grant", {28'b0, grant}, (m_phase == 0) ? 32'd0 : 32'(1 << m_owner));
      if (m_phase == 1) begin
        check("rnd_ack", {28'b0, ack}, 32'(1 << m_owner));
        check("rnd_byte", {24'b0, tx_byte}, {24'b0, qbuf[m_owner][qhead[m_owner]]});
        $display("[TB] rnd frame %0d req %0d byte %02h", frame_no, m_owner, tx_byte);
        frame_no++;
        qhead[m_owner] = (qhead[m_owner] + 1) % 8;
        qlen[m_owner]--;
      end
      if (m_phase == 0 && qlen[0] + qlen[1] + qlen[2] + qlen[3] == 0 && frames_left > 0) begin
        for (int k = 0; k < 4; k++) begin
          qlen[k] = $urandom_range(0, 3);
          for (int j = 0; j < qlen[k]; j++) qbuf[k][(qhead[k] + j) % 8] = 8'($urandom);
          frames_left -= qlen[k];
        end
      end
      for (int k = 0; k < 4; k++) begin
        dv[k] = (qlen[k] != 0);
        req_byte[8*k +: 8] = (qlen[k] != 0) ? qbuf[k][qhead[k]] : 8'h00;
        lock[k] = 1'($urandom_range(0, 1));
      end
      if (m_phase == 2) begin
        done = (cd == 0);
        if (cd > 0) cd--;
      end else begin
        done = ($urandom_range(0, 7) == 0);
      end
      // Advance the model with exactly what the next edge will sample
      case (m_phase)
        0: if (dv != 4'b0) begin
             w = rr_pick(dv, m_last);
             m_owner = w; m_last = w; m_phase = 1;
           end
        1: begin
             m_phase = 2;
             cd = $urandom_range(0, 12);
           end
        default: if (done) begin
             if (lock[m_owner] && dv[m_owner]) m_phase = 1;
             else begin
               m_phase = 0; m_owner = -1;
             end
           end
      endcase
      tick();
      cycles++;
    end
    check("rnd_finished_in_budget", {31'b0, cycles < 20000}, 32'd1);
    dv = 4'b0; lock = 4'b0; done = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
